// File: rtl/ram_bus_ctl.sv
// ram_bus_ctl - CPU-side request sequencer in front of the PSRAM `ram` block.
//
// Accepts single word/byte read/write requests from the core and turns each
// into a fixed-length level strobe (ram_read / ram_write). A recovery gap with
// both strobes low follows every strobe. Address, byte flag and write data are
// registered at accept. They stay frozen until the next accept, so they never
// move while a strobe is high.
//
// Build option: define RAM_BUS_CTL_POSTED_WR_EN to make writes posted. The
// write ack then pulses in the cycle after accept instead of at the end of
// the write hold.
//
// Ports:
//   mclk, rst_n                  clock, asynchronous active-low reset
//   cpu_req/we/byte/addr/wdata   core request (req held until cpu_ack)
//   cpu_rdata                    read data, updated with each read ack
//   cpu_ack                      one-cycle completion pulse
//   cpu_busy                     high whenever the sequencer is not idle
//   ram_read/ram_write           strobes to `ram`, never high together
//   ram_byte/ram_addr/ram_wdata  access qualifiers to `ram`
//   ram_rdata                    data from `ram`, valid only while ram_read is high
module ram_bus_ctl #(
  parameter int unsigned READ_HOLD  = 12,
  parameter int unsigned WRITE_HOLD = 12,
  parameter int unsigned RECOVER    = 4
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ram_byte,
  output logic [21:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_HOLD = 2'd1,
    ST_WR_HOLD = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] RD_LOAD = 8'(READ_HOLD - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_HOLD - 1);
  localparam logic [7:0] RC_LOAD = 8'(RECOVER - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        ram_read_q, ram_read_d;
  logic        ram_write_q, ram_write_d;
  logic        ram_byte_q, ram_byte_d;
  logic [21:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        accept_s;

  // Next-state, counter and output-register logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_byte_d  = ram_byte_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    // The last recovery edge doubles as an accept edge. This gives exactly
    // RECOVER strobe-low cycles and one transaction per HOLD+RECOVER cycles.
    accept_s = cpu_req && ((state_q == ST_IDLE) ||
                           ((state_q == ST_RECOVER) && (cnt_q == 8'd0)));

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RD_HOLD: begin
        if (cnt_q == 8'd0) begin
          // The capture happens while ram_read is still high, so the data is valid.
          cpu_rdata_d = ram_rdata;
          cpu_ack_d   = 1'b1;
          ram_read_d  = 1'b0;
          state_d     = ST_RECOVER;
          cnt_d       = RC_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WR_HOLD: begin
        if (cnt_q == 8'd0) begin
`ifdef RAM_BUS_CTL_POSTED_WR_EN
          cpu_ack_d   = 1'b0;
`else
          cpu_ack_d   = 1'b1;
`endif
          ram_write_d = 1'b0;
          state_d     = ST_RECOVER;
          cnt_d       = RC_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (accept_s) begin
      ram_byte_d  = cpu_byte;
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
      if (cpu_we) begin
        state_d     = ST_WR_HOLD;
        cnt_d       = WR_LOAD;
        ram_write_d = 1'b1;
`ifdef RAM_BUS_CTL_POSTED_WR_EN
        cpu_ack_d   = 1'b1;
`else
        cpu_ack_d   = 1'b0;
`endif
      end else begin
        state_d    = ST_RD_HOLD;
        cnt_d      = RD_LOAD;
        ram_read_d = 1'b1;
      end
    end else begin
      state_d = state_d;
    end

    cpu_busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs. Reset drops the strobes at once.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cpu_rdata_q <= 16'd0;
      cpu_ack_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_byte_q  <= 1'b0;
      ram_addr_q  <= 22'd0;
      ram_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_busy_q  <= cpu_busy_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_byte_q  <= ram_byte_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_busy  = cpu_busy_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_byte  = ram_byte_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_bus_ctl.sv
// tb_ram_bus_ctl - directed bench for ram_bus_ctl.
// Instance a uses the default timing. Instance b uses READ_HOLD=1 and
// RECOVER=1 for the corner case. Index i in the trace arrays is the value
// sampled on the falling edge after rising edge Ei, where E0 is the first
// edge of the traced transaction.
module tb_ram_bus_ctl;

  localparam int TMAX = 48;
`ifdef RAM_BUS_CTL_POSTED_WR_EN
  localparam int WR_ACK_IDX = 0;
`else
  localparam int WR_ACK_IDX = 12;
`endif

  logic        mclk = 1'b0;
  logic        rst_n;
  always #5 mclk = ~mclk;

  logic        cpu_req, cpu_we, cpu_byte;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_busy, ram_read, ram_write, ram_byte;
  logic [21:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata, rd_model;
  assign ram_rdata = ram_read ? rd_model : 16'hDEAD;

  logic        b_req, b_we, b_byte;
  logic [21:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic        b_ack, b_busy, b_ram_read, b_ram_write, b_ram_byte;
  logic [21:0] b_ram_addr;
  logic [15:0] b_ram_wdata, b_ram_rdata;
  assign b_ram_rdata = b_ram_read ? 16'h0BEE : 16'hDEAD;

  ram_bus_ctl u_a (
    .mclk(mclk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .ram_read(ram_read), .ram_write(ram_write), .ram_byte(ram_byte),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_bus_ctl #(.READ_HOLD(1), .WRITE_HOLD(12), .RECOVER(1)) u_b (
    .mclk(mclk), .rst_n(rst_n), .cpu_req(b_req), .cpu_we(b_we),
    .cpu_byte(b_byte), .cpu_addr(b_addr), .cpu_wdata(b_wdata),
    .cpu_rdata(b_rdata), .cpu_ack(b_ack), .cpu_busy(b_busy),
    .ram_read(b_ram_read), .ram_write(b_ram_write), .ram_byte(b_ram_byte),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic        tr_rd [TMAX];
  logic        tr_wr [TMAX];
  logic        tr_ack [TMAX];
  logic        tr_busy [TMAX];
  logic        stable_bad;
  int          n_ack;
  logic [15:0] ack_rdata;
  logic        nxt_valid;
  logic [21:0] nxt_addr;
  logic [15:0] nxt_model;

  // Step n cycles and record instance a. On an ack, either present the queued
  // follow-up read (req stays high) or drop req.
  task automatic trace(input int n);
    logic        p_strobe;
    logic [21:0] p_addr;
    logic        p_byte;
    logic [15:0] p_wdata;
    for (int i = 0; i < TMAX; i++) begin
      tr_rd[i] = 1'b0; tr_wr[i] = 1'b0; tr_ack[i] = 1'b0; tr_busy[i] = 1'b0;
    end
    p_strobe = 1'b0; p_addr = 22'd0; p_byte = 1'b0; p_wdata = 16'd0;
    stable_bad = 1'b0; n_ack = 0; ack_rdata = 16'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      @(negedge mclk);
      tr_rd[i] = ram_read; tr_wr[i] = ram_write;
      tr_ack[i] = cpu_ack; tr_busy[i] = cpu_busy;
      if (p_strobe && (ram_read || ram_write) &&
          ((ram_addr !== p_addr) || (ram_byte !== p_byte) || (ram_wdata !== p_wdata)))
        stable_bad = 1'b1;
      p_strobe = ram_read || ram_write;
      p_addr = ram_addr; p_byte = ram_byte; p_wdata = ram_wdata;
      if (cpu_ack === 1'b1) begin
        n_ack++;
        ack_rdata = cpu_rdata;
        if (nxt_valid) begin
          cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = nxt_addr;
          rd_model = nxt_model; nxt_valid = 1'b0;
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
  endtask

  // First index >= from where the chosen strobe rises (-1 if none).
  function automatic int rise_idx(input bit wr, input int from);
    int   r;
    logic cur, prv;
    r = -1;
    for (int i = from; i < TMAX; i++) begin
      cur = wr ? tr_wr[i] : tr_rd[i];
      prv = (i == 0) ? 1'b0 : (wr ? tr_wr[i-1] : tr_rd[i-1]);
      if ((r < 0) && cur && !prv) r = i;
    end
    return r;
  endfunction

  function automatic int count_hi(input bit wr);
    int c;
    c = 0;
    for (int i = 0; i < TMAX; i++) c += (wr ? int'(tr_wr[i]) : int'(tr_rd[i]));
    return c;
  endfunction

  task automatic test_reset;
    logic [58:0] outs;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = 22'h000200; cpu_wdata = 16'h1111; rd_model = 16'h5A5A;
    repeat (3) @(negedge mclk);
    outs = {cpu_rdata, cpu_ack, cpu_busy, ram_read, ram_write, ram_byte, ram_addr, ram_wdata};
    vectors++;
    if (outs !== 59'd0) begin
      miscompares++; $display("FAIL reset_outs_a: got %h want 0", outs);
    end
    outs = {b_rdata, b_ack, b_busy, b_ram_read, b_ram_write, b_ram_byte, b_ram_addr, b_ram_wdata};
    vectors++;
    if (outs !== 59'd0) begin
      miscompares++; $display("FAIL reset_outs_b: got %h want 0", outs);
    end
    rst_n = 1'b1;
    trace(20);
    vectors++;
    if (rise_idx(1'b0, 0) !== 0) begin
      miscompares++; $display("FAIL reset_first_accept: got %0d want 0", rise_idx(1'b0, 0));
    end
    vectors++;
    if ((tr_ack[12] !== 1'b1) || (ack_rdata !== 16'h5A5A)) begin
      miscompares++; $display("FAIL reset_first_read: ack12=%b rdata=%h want 1/5a5a", tr_ack[12], ack_rdata);
    end
  endtask

  task automatic test_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = 22'h000100; rd_model = 16'hA5C3;
    trace(24);
    vectors++;
    if ((rise_idx(1'b0, 0) !== 0) || (count_hi(1'b0) !== 12) || (tr_rd[11] !== 1'b1)) begin
      miscompares++; $display("FAIL read_strobe: rise=%0d cycles=%0d want 0/12", rise_idx(1'b0, 0), count_hi(1'b0));
    end
    vectors++;
    if ((n_ack !== 1) || (tr_ack[12] !== 1'b1)) begin
      miscompares++; $display("FAIL read_ack: count=%0d ack12=%b want 1/1", n_ack, tr_ack[12]);
    end
    vectors++;
    if (ack_rdata !== 16'hA5C3) begin
      miscompares++; $display("FAIL read_rdata: got %h want a5c3", ack_rdata);
    end
    vectors++;
    if ((tr_busy[15] !== 1'b1) || (tr_busy[16] !== 1'b0)) begin
      miscompares++; $display("FAIL read_busy: busy15=%b busy16=%b want 1/0", tr_busy[15], tr_busy[16]);
    end
    vectors++;
    if ((ram_addr !== 22'h000100) || (cpu_rdata !== 16'hA5C3)) begin
      miscompares++; $display("FAIL read_hold_regs: addr=%h rdata=%h want 000100/a5c3", ram_addr, cpu_rdata);
    end
  endtask

  task automatic test_byte_write;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1;
    cpu_addr = 22'h000101; cpu_wdata = 16'h7F00;
    trace(24);
    vectors++;
    if ((rise_idx(1'b1, 0) !== 0) || (count_hi(1'b1) !== 12) || (count_hi(1'b0) !== 0)) begin
      miscompares++; $display("FAIL bwr_strobe: rise=%0d wr=%0d rd=%0d want 0/12/0", rise_idx(1'b1, 0), count_hi(1'b1), count_hi(1'b0));
    end
    vectors++;
    if ((stable_bad !== 1'b0) || (ram_addr !== 22'h000101) || (ram_byte !== 1'b1) || (ram_wdata !== 16'h7F00)) begin
      miscompares++; $display("FAIL bwr_qualifiers: bad=%b addr=%h byte=%b wdata=%h want 0/000101/1/7f00", stable_bad, ram_addr, ram_byte, ram_wdata);
    end
    vectors++;
    if ((n_ack !== 1) || (tr_ack[WR_ACK_IDX] !== 1'b1)) begin
      miscompares++; $display("FAIL bwr_ack: count=%0d ack@%0d=%b want 1/1", n_ack, WR_ACK_IDX, tr_ack[WR_ACK_IDX]);
    end
    vectors++;
    if (cpu_rdata !== 16'hA5C3) begin
      miscompares++; $display("FAIL bwr_rdata_kept: got %h want a5c3", cpu_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int ovl;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
    cpu_addr = 22'h3FFFFE; cpu_wdata = 16'hBEEF;
    nxt_valid = 1'b1; nxt_addr = 22'h000010; nxt_model = 16'h0F0F;
    trace(40);
    ovl = 0;
    for (int i = 0; i < TMAX; i++) if (tr_rd[i] && tr_wr[i]) ovl++;
    vectors++;
    if (tr_ack[WR_ACK_IDX] !== 1'b1) begin
      miscompares++; $display("FAIL b2b_write_ack: ack@%0d=%b want 1", WR_ACK_IDX, tr_ack[WR_ACK_IDX]);
    end
    vectors++;
    if ((rise_idx(1'b1, 0) !== 0) || (rise_idx(1'b0, 0) !== 16)) begin
      miscompares++; $display("FAIL b2b_accepts: wr=%0d rd=%0d want 0/16", rise_idx(1'b1, 0), rise_idx(1'b0, 0));
    end
    vectors++;
    if ((ovl !== 0) || (stable_bad !== 1'b0)) begin
      miscompares++; $display("FAIL b2b_overlap: overlap=%0d unstable=%b want 0/0", ovl, stable_bad);
    end
    vectors++;
    if ((n_ack !== 2) || (tr_ack[28] !== 1'b1) || (ack_rdata !== 16'h0F0F)) begin
      miscompares++; $display("FAIL b2b_read: acks=%0d ack28=%b rdata=%h want 2/1/0f0f", n_ack, tr_ack[28], ack_rdata);
    end
  endtask

  task automatic test_reset_mid_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = 22'h000055; rd_model = 16'h1357;
    repeat (6) begin
      @(posedge mclk);
      @(negedge mclk);
    end
    vectors++;
    if (ram_read !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: ram_read=%b want 1", ram_read);
    end
    #2 rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    vectors++;
    if ((ram_read !== 1'b0) || (cpu_busy !== 1'b0)) begin
      miscompares++; $display("FAIL rst_mid_async: ram_read=%b busy=%b want 0/0", ram_read, cpu_busy);
    end
    @(negedge mclk);
    rst_n = 1'b1;
    trace(16);
    vectors++;
    if ((n_ack !== 0) || (count_hi(1'b0) !== 0)) begin
      miscompares++; $display("FAIL rst_mid_lost: acks=%0d rd=%0d want 0/0", n_ack, count_hi(1'b0));
    end
    cpu_req = 1'b1; cpu_addr = 22'h000056; rd_model = 16'h2468;
    trace(20);
    vectors++;
    if ((n_ack !== 1) || (tr_ack[12] !== 1'b1) || (ack_rdata !== 16'h2468) || (count_hi(1'b0) !== 12)) begin
      miscompares++; $display("FAIL rst_mid_recover: acks=%0d ack12=%b rdata=%h want 1/1/2468", n_ack, tr_ack[12], ack_rdata);
    end
  endtask

  task automatic test_param_corner;
    logic [7:0]  rd_pat, ack_pat;
    logic [15:0] b_cap;
    int          acks;
    rd_pat = 8'd0; ack_pat = 8'd0; b_cap = 16'd0; acks = 0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 22'h000040;
    for (int i = 0; i < 8; i++) begin
      @(posedge mclk);
      @(negedge mclk);
      rd_pat[i] = b_ram_read;
      ack_pat[i] = b_ack;
      if (b_ack === 1'b1) begin
        acks++;
        b_cap = b_rdata;
        if (acks == 1) b_addr = 22'h000042;
        else b_req = 1'b0;
      end
    end
    vectors++;
    if (rd_pat !== 8'b0000_0101) begin
      miscompares++; $display("FAIL corner_strobe: got %b want 00000101", rd_pat);
    end
    vectors++;
    if (ack_pat !== 8'b0000_1010) begin
      miscompares++; $display("FAIL corner_ack: got %b want 00001010", ack_pat);
    end
    vectors++;
    if ((b_cap !== 16'h0BEE) || (b_ram_addr !== 22'h000042)) begin
      miscompares++; $display("FAIL corner_data: rdata=%h addr=%h want 0bee/000042", b_cap, b_ram_addr);
    end
  endtask

  initial begin
    b_req = 1'b0; b_we = 1'b0; b_byte = 1'b0; b_addr = 22'd0; b_wdata = 16'd0;
    nxt_valid = 1'b0; nxt_addr = 22'd0; nxt_model = 16'd0;
    test_reset();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_reset_mid_read();
    test_param_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
